pkt_queue_merge: RTL



---
 rtl/pkt_queue_merge_pkg.sv | 27 ++
 rtl/pkt_queue_merge.sv | 111 +++++++++++
 2 files changed

// File: rtl/pkt_queue_merge_pkg.sv
// Shared definitions for the packet queue merge: queue tag location,
// FSM encoding and the one-hot tag decoder.
package pkt_queue_merge_pkg;

   localparam int C_NUM_QUEUES = 4;
   localparam int C_QID_LSB    = 141;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Decode a 4-bit queue tag; returns {valid, idx}. valid is set only
   // when exactly one tag bit is high.
   function automatic logic [2:0] onehot4_to_idx(input logic [3:0] tag);
      logic [2:0] res;
      case (tag)
         4'b0001: res = 3'b100;
         4'b0010: res = 3'b101;
         4'b0100: res = 3'b110;
         4'b1000: res = 3'b111;
         default: res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pkt_queue_merge.sv
// Reader side of the four-way packet cache. Each accepted PHV selects one
// queue through its one-hot tag; exactly one packet is streamed from that
// queue while the PHV is held on phv_out.
module pkt_queue_merge
   import pkt_queue_merge_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int PKT_HDR_LEN          = 1024
) (
   input  logic                                          axis_clk,
   input  logic                                          aresetn,
   input  logic [PKT_HDR_LEN-1:0]                        phv_in,
   input  logic                                          phv_valid_in,
   output logic                                          phv_ready_out,
   input  logic [C_NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_q,
   input  logic [C_NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser_q,
   input  logic [C_NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep_q,
   input  logic [C_NUM_QUEUES-1:0]                       s_axis_tlast_q,
   input  logic [C_NUM_QUEUES-1:0]                       s_axis_tvalid_q,
   output logic [C_NUM_QUEUES-1:0]                       s_axis_tready_q,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
   output logic                                          m_axis_tlast,
   output logic                                          m_axis_tvalid,
   input  logic                                          m_axis_tready,
   output logic [PKT_HDR_LEN-1:0]                        phv_out,
   output logic                                          phv_out_valid,
   output logic                                          err_bad_qid,
   output logic [31:0]                                   pkt_cnt
);

   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;
   localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

   logic [1:0] rst_sync;
   logic       rst_n;
   state_t     state, state_nxt;
   logic [1:0] sel;
   logic [2:0] qid;
   logic       phv_take;
   logic       beat_done;

   // Reset asserts immediately, releases two clock edges after aresetn rises
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n    = rst_sync[1];
   assign qid      = onehot4_to_idx(phv_in[C_QID_LSB +: 4]);
   assign phv_take = phv_valid_in && phv_ready_out;

   // Data path of the selected queue is a plain mux; only the handshake
   // signals are qualified by the state.
   assign m_axis_tdata = s_axis_tdata_q[sel*DW +: DW];
   assign m_axis_tuser = s_axis_tuser_q[sel*UW +: UW];
   assign m_axis_tkeep = s_axis_tkeep_q[sel*KW +: KW];
   assign beat_done    = (state == FLUSH) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // State register
   always_ff @(posedge axis_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nxt       = state;
      phv_ready_out   = 1'b0;
      phv_out_valid   = 1'b0;
      s_axis_tready_q = '0;
      m_axis_tvalid   = 1'b0;
      m_axis_tlast    = 1'b0;
      case (state)
         IDLE: begin
            // rst_n keeps the PHV port closed until the reset has released
            phv_ready_out = rst_n;
            if (phv_valid_in && rst_n && qid[2]) state_nxt = FLUSH;
         end
         FLUSH: begin
            phv_out_valid        = 1'b1;
            m_axis_tvalid        = s_axis_tvalid_q[sel];
            m_axis_tlast         = s_axis_tlast_q[sel];
            s_axis_tready_q[sel] = m_axis_tready;
            if (s_axis_tvalid_q[sel] && m_axis_tready && s_axis_tlast_q[sel]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // PHV capture, queue select, error pulse and packet counter
   always_ff @(posedge axis_clk or negedge rst_n) begin
      if (!rst_n) begin
         phv_out     <= '0;
         sel         <= 2'd0;
         err_bad_qid <= 1'b0;
         pkt_cnt     <= 32'd0;
      end else begin
         err_bad_qid <= phv_take && !qid[2];
         if (phv_take && qid[2]) begin
            phv_out <= phv_in;
            sel     <= qid[1:0];
         end
         if (beat_done) pkt_cnt <= pkt_cnt + 32'd1;
      end
   end

endmodule
